truth_table_sweeper: RTL

Self-checking exhaustive stimulus engine for small combinational blocks. On a start request it drives every input combination 0 … 2^N−1 onto a DUT and holds each one for a programmable settle time. It then samples the DUT response, compares it against a parameterised expected truth table, and reports an error count, the first failing vector and a pass/fail verdict. It sits beside the unit under test in simulation benches and FPGA bring-up builds, replacing hand-written per-vector stimulus.

---
 rtl/truth_table_sweeper.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/truth_table_sweeper.sv
// ============================================================================
// truth_table_sweeper: exhaustive stimulus engine that drives every input
// vector to a combinational DUT and checks the response against a table.
// Revision: 1.0
// ============================================================================
`default_nettype none

module truth_table_sweeper #(
  parameter int N      = 3,
  parameter int OUT_W  = 1,
  parameter int SETTLE = 2,
  parameter logic [(2**N)*OUT_W-1:0] EXP = 8'hE8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic [OUT_W-1:0] dut_o,
  output logic [N-1:0]     vec_o,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [N:0]       err_cnt,
  output logic [N-1:0]     first_fail,
  output logic [OUT_W-1:0] first_fail_got,
  output logic             first_fail_vld
);

  localparam int           NVEC        = 2**N;
  localparam logic [N-1:0] VEC_LAST    = {N{1'b1}};
  localparam logic [3:0]   SETTLE_LAST = 4'(SETTLE - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [3:0]       settle_q, settle_d;
  logic [N-1:0]     vec_q, vec_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             pass_q, pass_d;
  logic [N:0]       err_q, err_d;
  logic [N-1:0]     ff_q, ff_d;
  logic [OUT_W-1:0] ff_got_q, ff_got_d;
  logic             ff_vld_q, ff_vld_d;

  // Expected table unpacked so the current entry is a plain array lookup.
  logic [OUT_W-1:0] exp_tbl [NVEC];
  logic [OUT_W-1:0] exp_entry;
  logic             mismatch;
  logic [N:0]       err_inc;

  for (genvar k = 0; k < NVEC; k++) begin : g_exp_tbl
    assign exp_tbl[k] = EXP[k*OUT_W +: OUT_W];
  end

  always_comb begin
    exp_entry = exp_tbl[vec_q];
    mismatch  = (dut_o != exp_entry);
    err_inc   = err_q + {{N{1'b0}}, mismatch};
  end

  always_comb begin
    state_d  = state_q;
    settle_d = settle_q;
    vec_d    = vec_q;
    busy_d   = busy_q;
    done_d   = done_q;
    pass_d   = pass_q;
    err_d    = err_q;
    ff_d     = ff_q;
    ff_got_d = ff_got_q;
    ff_vld_d = ff_vld_q;

    if (abort) begin
      // Partial results are kept so a cancelled sweep can still be inspected.
      state_d  = ST_IDLE;
      settle_d = '0;
      vec_d    = '0;
      busy_d   = 1'b0;
      done_d   = 1'b0;
      pass_d   = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            state_d  = ST_RUN;
            settle_d = '0;
            vec_d    = '0;
            busy_d   = 1'b1;
            done_d   = 1'b0;
            pass_d   = 1'b0;
            err_d    = '0;
            ff_d     = '0;
            ff_got_d = '0;
            ff_vld_d = 1'b0;
          end
        end
        ST_RUN: begin
          if (settle_q != SETTLE_LAST) begin
            settle_d = settle_q + 4'd1;
          end else begin
            err_d = err_inc;
            if (mismatch && !ff_vld_q) begin
              ff_d     = vec_q;
              ff_got_d = dut_o;
              ff_vld_d = 1'b1;
            end
            settle_d = '0;
            // Terminal test precedes the increment, so vec never wraps.
            if (vec_q != VEC_LAST) begin
              vec_d = vec_q + 1'b1;
            end else begin
              state_d = ST_DONE;
              busy_d  = 1'b0;
              done_d  = 1'b1;
              pass_d  = (err_inc == '0);
            end
          end
        end
        default: begin
          state_d  = ST_IDLE;
          settle_d = '0;
          vec_d    = '0;
          busy_d   = 1'b0;
          done_d   = 1'b0;
          pass_d   = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      settle_q <= '0;
      vec_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      pass_q   <= 1'b0;
      err_q    <= '0;
      ff_q     <= '0;
      ff_got_q <= '0;
      ff_vld_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      settle_q <= settle_d;
      vec_q    <= vec_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      pass_q   <= pass_d;
      err_q    <= err_d;
      ff_q     <= ff_d;
      ff_got_q <= ff_got_d;
      ff_vld_q <= ff_vld_d;
    end
  end

  assign vec_o          = vec_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign pass           = pass_q;
  assign err_cnt        = err_q;
  assign first_fail     = ff_q;
  assign first_fail_got = ff_got_q;
  assign first_fail_vld = ff_vld_q;

endmodule

`default_nettype wire
